// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: immsrc encodings and XLEN default.
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_CSR = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode from instr[31:7] to {immext, illegal}.
// IMM_CSR_UIMM_EN enables immsrc=101 as the zero-extended CSR uimm; otherwise 101 is reserved.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  // Indexed as the architectural bit positions so the format table reads directly.
  logic [31:7] x;
  logic [31:0] imm32;
  logic        sext;

  assign x = instr;

  always_comb begin
    imm32   = '0;
    sext    = 1'b1;
    illegal = 1'b0;
    case (immsrc)
      IMM_I:   imm32 = {{20{x[31]}}, x[31:20]};
      IMM_S:   imm32 = {{20{x[31]}}, x[31:25], x[11:7]};
      IMM_B:   imm32 = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      IMM_J:   imm32 = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      IMM_U:   imm32 = {x[31:12], 12'b0};
`ifdef IMM_CSR_UIMM_EN
      IMM_CSR: begin
        imm32 = {27'b0, x[19:15]};
        sext  = 1'b0;
      end
`endif
      default: illegal = 1'b1;
    endcase
    immext = sext ? XLEN'(signed'(imm32)) : XLEN'(imm32);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode registered behind a valid/ready handshake
// with a main output register and one skid entry. Optional feature macro: IMM_CSR_UIMM_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  logic             main_v_q,   main_v_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_ill_q, main_ill_d;
  logic             skid_v_q,   skid_v_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .immsrc  (immsrc),
    .immext  (dec_imm),
    .illegal (dec_ill)
  );

  always_comb begin
    main_v_d   = main_v_q;
    main_imm_d = main_imm_q;
    main_tag_d = main_tag_q;
    main_ill_d = main_ill_q;
    skid_v_d   = skid_v_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_ill_d = skid_ill_q;
    // in_ready is !skid_v_q, so no input can arrive on a cycle the skid entry refills main.
    if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_v_d   = 1'b1;
        main_imm_d = skid_imm_q;
        main_tag_d = skid_tag_q;
        main_ill_d = skid_ill_q;
        skid_v_d   = 1'b0;
      end else begin
        main_v_d = in_valid;
        if (in_valid) begin
          main_imm_d = dec_imm;
          main_tag_d = in_tag;
          main_ill_d = dec_ill;
        end
      end
    end else if (in_valid && !skid_v_q) begin
      skid_v_d   = 1'b1;
      skid_imm_d = dec_imm;
      skid_tag_d = in_tag;
      skid_ill_d = dec_ill;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q   <= 1'b0;
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_ill_q <= 1'b0;
      skid_v_q   <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      main_v_q   <= main_v_d;
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      main_ill_q <= main_ill_d;
      skid_v_q   <= skid_v_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign immext    = main_imm_q;
  assign out_tag   = main_tag_q;
  assign illegal   = main_ill_q;

endmodule
